m_memarb: RTL and testbench

Single-port memory arbiter for the five-stage processor. It shares one `m_memory` instance (1-cycle synchronous read, write on clock edge) between the IF-stage instruction port and the MEM-stage data port. Requests are granted combinationally, and read data returns one cycle later with a registered valid. The block also produces an IF stall and counts conflict cycles, so pipeline control and benches can see the memory pressure.

---
 rtl/m_memarb.sv | 109 ++++++++++
 tb/tb_m_memarb.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_memarb.sv
// m_memarb: single-port memory arbiter shared by the IF and MEM stages.
// Build option: define MEMARB_STARVE_EN to bound instruction-port starvation.
module m_memarb #(
  parameter int AW         = 12,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          w_clk,
  input  logic          w_rst,
  input  logic          w_ireq,
  input  logic [AW-1:0] w_iaddr,
  output logic          w_igrant,
  output logic          r_ivalid,
  output logic [DW-1:0] w_irdata,
  input  logic          w_dreq,
  input  logic          w_dwe,
  input  logic [AW-1:0] w_daddr,
  input  logic [DW-1:0] w_dwdata,
  output logic          w_dgrant,
  output logic          r_dvalid,
  output logic [DW-1:0] w_drdata,
  output logic          w_stall_if,
  output logic [AW-1:0] w_maddr,
  output logic          w_mwe,
  output logic [DW-1:0] w_mdin,
  input  logic [DW-1:0] w_mrdata,
  output logic [31:0]   r_conflicts
);

  localparam logic OWN_D = 1'b0;
  localparam logic OWN_I = 1'b1;

  logic w_both;
  logic w_pick_i;
  logic r_own;
  logic r_busy;

  assign w_both = w_ireq & w_dreq;

`ifdef MEMARB_STARVE_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] r_starve;

  // Instruction port overrides data priority once its wait hits the cap.
  assign w_pick_i = w_both & (r_starve == SMAX);

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_starve <= '0;
    end else if (!w_ireq || w_igrant) begin
      r_starve <= '0;
    end else if (w_dgrant) begin
      r_starve <= r_starve + 1'b1;
    end
  end
`else
  // Strict data priority; the cap only matters in the starvation build.
  assign w_pick_i = w_both & (STARVE_MAX < 0);
`endif

  assign w_igrant   = ~w_rst & w_ireq & (~w_dreq | w_pick_i);
  assign w_dgrant   = ~w_rst & w_dreq & ~w_pick_i;
  assign w_stall_if = w_ireq & ~w_igrant;

  always_comb begin
    w_maddr = '0;
    w_mwe   = 1'b0;
    w_mdin  = '0;
    unique case (1'b1)
      w_igrant: begin
        w_maddr = w_iaddr;
      end
      w_dgrant: begin
        w_maddr = w_daddr;
        w_mwe   = w_dwe;
        w_mdin  = w_dwdata;
      end
      default: begin
        w_maddr = '0;
      end
    endcase
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_own       <= OWN_D;
      r_busy      <= 1'b0;
      r_conflicts <= '0;
    end else begin
      r_busy <= w_igrant | w_dgrant;
      if (w_igrant) begin
        r_own <= OWN_I;
      end else if (w_dgrant) begin
        r_own <= OWN_D;
      end
      if (w_both) begin
        r_conflicts <= r_conflicts + 32'd1;
      end
    end
  end

  assign r_ivalid = r_busy & (r_own == OWN_I);
  assign r_dvalid = r_busy & (r_own == OWN_D);
  assign w_irdata = w_mrdata;
  assign w_drdata = w_mrdata;

endmodule

// File: tb/tb_m_memarb.sv
// tb_m_memarb: directed and randomized checks of m_memarb
// against a cycle-level arbitration model and a shadow memory.
module tb_m_memarb;
  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int SMAX = 4;
`ifdef MEMARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic          w_clk = 1'b0;
  logic          w_rst;
  logic          w_ireq;
  logic [AW-1:0] w_iaddr;
  logic          w_igrant;
  logic          r_ivalid;
  logic [DW-1:0] w_irdata;
  logic          w_dreq;
  logic          w_dwe;
  logic [AW-1:0] w_daddr;
  logic [DW-1:0] w_dwdata;
  logic          w_dgrant;
  logic          r_dvalid;
  logic [DW-1:0] w_drdata;
  logic          w_stall_if;
  logic [AW-1:0] w_maddr;
  logic          w_mwe;
  logic [DW-1:0] w_mdin;
  logic [DW-1:0] w_mrdata;
  logic [31:0]   r_conflicts;

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 w_clk = ~w_clk;

  always @(posedge w_clk) begin
    if (w_mwe) mem[w_maddr] <= w_mdin;
    w_mrdata <= mem[w_maddr];
  end

  m_memarb #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .w_clk(w_clk), .w_rst(w_rst),
    .w_ireq(w_ireq), .w_iaddr(w_iaddr),
    .w_igrant(w_igrant), .r_ivalid(r_ivalid),
    .w_irdata(w_irdata),
    .w_dreq(w_dreq), .w_dwe(w_dwe),
    .w_daddr(w_daddr), .w_dwdata(w_dwdata),
    .w_dgrant(w_dgrant), .r_dvalid(r_dvalid),
    .w_drdata(w_drdata), .w_stall_if(w_stall_if),
    .w_maddr(w_maddr), .w_mwe(w_mwe),
    .w_mdin(w_mdin), .w_mrdata(w_mrdata),
    .r_conflicts(r_conflicts)
  );

  task automatic idle();
    w_ireq   = 1'b0;
    w_iaddr  = '0;
    w_dreq   = 1'b0;
    w_dwe    = 1'b0;
    w_daddr  = '0;
    w_dwdata = '0;
  endtask

  task automatic do_reset();
    @(negedge w_clk);
    idle();
    w_rst = 1'b1;
    @(negedge w_clk);
    w_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    w_ireq  = 1'b1;
    w_iaddr = 12'd3;
    @(negedge w_clk);
    idle();
    n_tests++;
    if (r_ivalid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_ivalid got=%b exp=1", r_ivalid);
    end
    #2;
    w_rst  = 1'b1;
    w_ireq = 1'b1;
    w_dreq = 1'b1;
    #1;
    n_tests++;
    if (r_ivalid !== 1'b0 || r_dvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valids got=%b%b exp=00", r_ivalid, r_dvalid);
    end
    n_tests++;
    if (w_igrant !== 1'b0 || w_dgrant !== 1'b0 || w_mwe !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_grants got=%b%b%b exp=000",
               w_igrant, w_dgrant, w_mwe);
    end
    n_tests++;
    if (w_stall_if !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_stall_hi got=%b exp=1", w_stall_if);
    end
    w_ireq = 1'b0;
    #1;
    n_tests++;
    if (w_stall_if !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_stall_lo got=%b exp=0", w_stall_if);
    end
    w_ireq = 1'b1;
    @(posedge w_clk);
    #1;
    n_tests++;
    if (r_conflicts !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_conflicts got=%0d exp=0", r_conflicts);
    end
    @(negedge w_clk);
    idle();
    w_rst = 1'b0;
  endtask

  task automatic test_ifetch();
    mem[5]     = 32'h2129_0001;
    ref_mem[5] = 32'h2129_0001;
    w_ireq  = 1'b1;
    w_iaddr = 12'h005;
    #1;
    n_tests++;
    if (w_igrant !== 1'b1 || w_stall_if !== 1'b0) begin
      n_fail++;
      $display("FAIL if_grant got=%b stall=%b exp=1/0", w_igrant, w_stall_if);
    end
    n_tests++;
    if (w_maddr !== 12'h005 || w_mwe !== 1'b0) begin
      n_fail++;
      $display("FAIL if_maddr got=%h we=%b exp=005/0", w_maddr, w_mwe);
    end
    @(negedge w_clk);
    idle();
    n_tests++;
    if (r_ivalid !== 1'b1 || w_irdata !== 32'h2129_0001) begin
      n_fail++;
      $display("FAIL if_data got=%b/%h exp=1/21290001", r_ivalid, w_irdata);
    end
    @(negedge w_clk);
    n_tests++;
    if (r_ivalid !== 1'b0) begin
      n_fail++;
      $display("FAIL if_valid_drop got=%b exp=0", r_ivalid);
    end
  endtask

  task automatic test_write_read();
    w_dreq   = 1'b1;
    w_dwe    = 1'b1;
    w_daddr  = 12'h010;
    w_dwdata = 32'hDEAD_BEEF;
    #1;
    n_tests++;
    if (w_dgrant !== 1'b1 || w_mwe !== 1'b1 || w_mdin !== 32'hDEAD_BEEF ||
        w_maddr !== 12'h010) begin
      n_fail++;
      $display("FAIL wr_issue got=%b%b %h %h exp=11 deadbeef 010",
               w_dgrant, w_mwe, w_mdin, w_maddr);
    end
    @(negedge w_clk);
    ref_mem[16] = 32'hDEAD_BEEF;
    n_tests++;
    if (r_dvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_ack got=%b exp=1", r_dvalid);
    end
    w_dwe = 1'b0;
    #1;
    n_tests++;
    if (w_dgrant !== 1'b1 || w_mwe !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_issue got=%b%b exp=10", w_dgrant, w_mwe);
    end
    @(negedge w_clk);
    idle();
    n_tests++;
    if (r_dvalid !== 1'b1 || w_drdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL rd_data got=%b/%h exp=1/deadbeef", r_dvalid, w_drdata);
    end
  endtask

  task automatic test_conflict();
    int exp_ig;
    int seen_ig;
    bit exp_i;
    do_reset();
    exp_ig  = 0;
    seen_ig = 0;
    w_ireq  = 1'b1;
    w_iaddr = 12'd7;
    w_dreq  = 1'b1;
    w_dwe   = 1'b0;
    w_daddr = 12'd9;
    for (int c = 0; c < 10; c++) begin
      #1;
      exp_i = STARVE_ON && ((c % (SMAX + 1)) == SMAX);
      if (exp_i) exp_ig++;
      if (w_igrant) seen_ig++;
      n_tests++;
      if (w_igrant !== exp_i || w_dgrant !== !exp_i ||
          w_stall_if !== !exp_i) begin
        n_fail++;
        $display("FAIL conflict_c%0d got=i%b d%b s%b exp_i=%b",
                 c, w_igrant, w_dgrant, w_stall_if, exp_i);
      end
      @(negedge w_clk);
    end
    n_tests++;
    if (r_conflicts !== 32'd10) begin
      n_fail++;
      $display("FAIL conflict_count got=%0d exp=10", r_conflicts);
    end
    n_tests++;
    if (seen_ig != exp_ig) begin
      n_fail++;
      $display("FAIL conflict_igrants got=%0d exp=%0d", seen_ig, exp_ig);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    w_dreq  = 1'b1;
    w_dwe   = 1'b0;
    w_daddr = 12'h010;
    #1;
    n_tests++;
    if (w_dgrant !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_grant got=%b exp=1", w_dgrant);
    end
    #1;
    w_rst = 1'b1;
    #1;
    n_tests++;
    if (w_dgrant !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_grant_rst got=%b exp=0", w_dgrant);
    end
    @(negedge w_clk);
    n_tests++;
    if (r_dvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_cancel got=%b exp=0", r_dvalid);
    end
    idle();
    w_rst = 1'b0;
    @(negedge w_clk);
    n_tests++;
    if (r_dvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_idle got=%b exp=0", r_dvalid);
    end
    w_dreq  = 1'b1;
    w_daddr = 12'h010;
    #1;
    n_tests++;
    if (w_dgrant !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_regrant got=%b exp=1", w_dgrant);
    end
    @(negedge w_clk);
    idle();
    n_tests++;
    if (r_dvalid !== 1'b1 || w_drdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL mid_data got=%b/%h exp=1/deadbeef", r_dvalid, w_drdata);
    end
  endtask

  task automatic test_random(input int ncyc);
    logic          iq, dq, dwe;
    logic [AW-1:0] ia, da, exp_a;
    logic [DW-1:0] dwd, exp_id, exp_dd;
    bit            gi, gd, exp_iv, exp_dv, exp_rd;
    int            streak, confl;
    do_reset();
    iq = 0; dq = 0; dwe = 0; ia = '0; da = '0; dwd = '0;
    exp_iv = 0; exp_dv = 0; exp_rd = 0;
    exp_id = '0; exp_dd = '0;
    streak = 0; confl = 0;
    for (int k = 0; k < ncyc; k++) begin
      n_tests++;
      if (r_ivalid !== exp_iv || (exp_iv && w_irdata !== exp_id)) begin
        n_fail++;
        $display("FAIL rnd_i k=%0d got=%b/%h exp=%b/%h",
                 k, r_ivalid, w_irdata, exp_iv, exp_id);
      end
      n_tests++;
      if (r_dvalid !== exp_dv || (exp_rd && w_drdata !== exp_dd)) begin
        n_fail++;
        $display("FAIL rnd_d k=%0d got=%b/%h exp=%b/%h",
                 k, r_dvalid, w_drdata, exp_dv, exp_dd);
      end
      if (!iq) begin
        iq = ($urandom_range(0, 2) != 0);
        ia = AW'($urandom_range(0, 31));
      end else if ($urandom_range(0, 15) == 0) begin
        iq = 1'b0;
      end
      if (!dq) begin
        dq  = ($urandom_range(0, 2) != 0);
        dwe = $urandom_range(0, 1) == 1;
        da  = AW'($urandom_range(0, 31));
        dwd = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        dq = 1'b0;
      end
      w_ireq = iq; w_iaddr = ia;
      w_dreq = dq; w_dwe = dwe; w_daddr = da; w_dwdata = dwd;
      #1;
      gi = iq && (!dq || (STARVE_ON && streak == SMAX));
      gd = dq && !gi;
      exp_a = gi ? ia : (gd ? da : '0);
      n_tests++;
      if (w_igrant !== gi || w_dgrant !== gd || w_stall_if !== (iq && !gi)) begin
        n_fail++;
        $display("FAIL rnd_grant k=%0d got=i%b d%b s%b exp=i%b d%b",
                 k, w_igrant, w_dgrant, w_stall_if, gi, gd);
      end
      n_tests++;
      if (w_maddr !== exp_a || w_mwe !== (gd && dwe) ||
          ((gd && dwe) && w_mdin !== dwd) || (!gi && !gd && w_mdin !== '0)) begin
        n_fail++;
        $display("FAIL rnd_mem k=%0d got=%h/%b/%h exp=%h/%b",
                 k, w_maddr, w_mwe, w_mdin, exp_a, gd && dwe);
      end
      if (iq && dq) confl++;
      if (!iq || gi) streak = 0;
      else if (gd) streak++;
      exp_iv = gi;
      exp_id = ref_mem[ia];
      exp_dv = gd;
      exp_rd = gd && !dwe;
      exp_dd = ref_mem[da];
      if (gd && dwe) ref_mem[da] = dwd;
      if (gi) iq = 1'b0;
      if (gd) dq = 1'b0;
      @(negedge w_clk);
    end
    idle();
    n_tests++;
    if (r_ivalid !== exp_iv || (exp_iv && w_irdata !== exp_id) ||
        r_dvalid !== exp_dv || (exp_rd && w_drdata !== exp_dd)) begin
      n_fail++;
      $display("FAIL rnd_tail got=%b%b exp=%b%b",
               r_ivalid, r_dvalid, exp_iv, exp_dv);
    end
    n_tests++;
    if (r_conflicts !== 32'(confl)) begin
      n_fail++;
      $display("FAIL rnd_conflicts got=%0d exp=%0d", r_conflicts, confl);
    end
  endtask

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < (1 << AW); i++) begin
      v          = $urandom;
      mem[i]     = v;
      ref_mem[i] = v;
    end
    w_mrdata = '0;
    idle();
    w_rst = 1'b1;
    test_reset();
    test_ifetch();
    test_write_read();
    test_conflict();
    test_reset_mid();
    test_random(600);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
